display_scan: RTL and testbench

- Time-multiplexed scanner for a common-anode 7-segment display bank.
- Latches a packed hex value, walks one digit per refresh slot, and drives the selected nibble to the downstream sevseg decoder with one active-low digit enable.
- Double-buffered: new values take effect only at frame boundaries (no tearing).
- Provides anti-ghosting guard time and optional leading-zero blanking.

---
 rtl/display_pkg.sv | 31 +++
 rtl/display_scan_timer.sv | 41 ++++
 rtl/display_scan.sv | 104 ++++++++++
 tb/tb_display_scan.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, types and the leading-zero blanking helper for display_scan.
// Pure declarations, no state.
// Used by the top level and the scan timer.
package display_pkg;

  localparam int   DIGIT_W    = 4;
  localparam int   MAX_DIGITS = 8;
  localparam logic BLANK_EN   = '1;

  typedef logic [DIGIT_W-1:0] nibble_t;

  // Bit k is set when digit k is a leading zero: k > 0 and every nibble from k
  // up to the most significant used digit is zero. Digit 0 is never blanked.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [DIGIT_W*MAX_DIGITS-1:0] disp,
    input int                            n
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < n) begin
        zero_above = zero_above && (disp[k*DIGIT_W +: DIGIT_W] == '0);
        mask[k]    = zero_above;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot counter and digit index for the display scanner.
// tick/frame_wrap/guard are combinational from the registered count.
// Free-running; no backpressure.
module scan_timer
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 27000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        tick,
  output logic                        frame_wrap,
  output logic                        guard,
  output logic [$clog2(N_DIGITS)-1:0] idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic [CNT_W-1:0] cnt;

  assign tick       = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_wrap = tick && (idx == IDX_W'(N_DIGITS - 1));
  assign guard      = (cnt < CNT_W'(GUARD_CYCLES));

  // Slot counter wraps every REFRESH_DIV cycles; idx steps one digit per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= frame_wrap ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous double buffering.
// Outputs registered, one cycle after the slot counter/index.
// load_i always accepted; later loads overwrite the pending value.
module display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 27000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   value_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  output logic                    load_ack_o,
  output logic [DIGIT_W-1:0]      bcd_o,
  output logic [N_DIGITS-1:0]     digit_en_o
);

  localparam int IDX_W = $clog2(N_DIGITS);

  logic                          tick;
  logic                          frame_wrap;
  logic                          guard;
  logic [IDX_W-1:0]              idx;
  logic                          wrap_now;
  logic [4*N_DIGITS-1:0]         display;
  logic [4*N_DIGITS-1:0]         pending;
  logic                          pending_valid;
  logic [DIGIT_W*MAX_DIGITS-1:0] disp_ext;
  logic [MAX_DIGITS-1:0]         blank_mask;
  nibble_t                       sel_nib;
  logic                          blank_now;
  logic [N_DIGITS-1:0]           onehot;

  scan_timer #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .frame_wrap(frame_wrap),
    .guard     (guard),
    .idx       (idx)
  );

  // frame_wrap already implies tick; gating keeps the swap point explicit.
  assign wrap_now = tick && frame_wrap;

  // Double buffer: loads park in pending and are promoted only at a frame wrap,
  // so a frame never mixes old and new digits. A load on the wrap cycle bypasses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      load_ack_o    <= 1'b0;
    end else begin
      load_ack_o <= 1'b0;
      if (wrap_now && load_i) begin
        display       <= value_i;
        pending_valid <= 1'b0;
        load_ack_o    <= 1'b1;
      end else begin
        if (wrap_now && pending_valid) begin
          display       <= pending;
          pending_valid <= 1'b0;
          load_ack_o    <= 1'b1;
        end
        if (load_i) begin
          pending       <= value_i;
          pending_valid <= 1'b1;
        end
      end
    end
  end

  // Current digit nibble, its blank decision and its one-hot enable.
  always_comb begin
    disp_ext                   = '0;
    disp_ext[4*N_DIGITS-1:0]   = display;
    blank_mask                 = lz_mask(disp_ext, N_DIGITS);
    sel_nib                    = display[idx*DIGIT_W +: DIGIT_W];
    blank_now                  = (blank_lz_i == BLANK_EN) && blank_mask[idx];
    onehot                     = '0;
    onehot[idx]                = 1'b1;
  end

  // Output registers; bcd_o keeps tracking the slot digit through the guard
  // time so the decoder is settled before the enable goes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_o      <= '0;
      digit_en_o <= '1;
    end else begin
      bcd_o      <= sel_nib;
      digit_en_o <= (guard || blank_now) ? '1 : ~onehot;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (N_DIGITS=4, REFRESH_DIV=6, GUARD_CYCLES=2).
// Every cycle is checked against a time-based reference model.
// Stimulus: directed scenarios followed by random loads and blank changes.
module tb_display_scan;

  localparam int N   = 4;
  localparam int DIV = 6;
  localparam int GRD = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blz = 1'b0;
  logic        load_ack;
  logic [3:0]  bcd;
  logic [3:0]  digit_en;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;

  // Reference model: cycles since reset release plus the buffered values.
  int          t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv = 1'b0;

  always #5 clk = ~clk;

  display_scan #(
    .N_DIGITS    (N),
    .REFRESH_DIV (DIV),
    .GUARD_CYCLES(GRD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_i   (value),
    .load_i    (load),
    .blank_lz_i(blz),
    .load_ack_o(load_ack),
    .bcd_o     (bcd),
    .digit_en_o(digit_en)
  );

  task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
    end
  endtask

  // One clock with the given load request; outputs checked 1 time unit after the edge.
  task automatic step(input logic ld, input logic [15:0] v);
    int          cnt;
    int          di;
    bit          wrap;
    bit          blanked;
    logic [3:0]  e_en;
    logic [3:0]  e_bcd;
    logic        e_ack;
    load  = ld;
    value = v;
    cnt   = t % DIV;
    di    = (t / DIV) % N;
    wrap  = (t % FRAME) == FRAME - 1;
    blanked = blz && (di > 0) && ((m_disp >> (4 * di)) == 16'd0);
    e_en  = (cnt < GRD || blanked) ? 4'hF : (4'hF ^ (4'h1 << di));
    e_bcd = 4'((m_disp >> (4 * di)) & 16'hF);
    e_ack = wrap && (m_pv || ld);
    @(posedge clk);
    #1;
    load = 1'b0;
    check4("digit_en", digit_en, e_en);
    check4("bcd", bcd, e_bcd);
    check1("ack", load_ack, e_ack);
    if (load_ack === 1'b1) ack_cnt++;
    if (wrap && ld) begin
      m_disp = v;
      m_pv   = 1'b0;
    end else begin
      if (wrap && m_pv) begin
        m_disp = m_pend;
        m_pv   = 1'b0;
      end
      if (ld) begin
        m_pend = v;
        m_pv   = 1'b1;
      end
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  // Advance so that the next step() lands on the frame-wrap cycle.
  task automatic to_wrap();
    while ((t % FRAME) != FRAME - 1) step(1'b0, 16'h0);
  endtask

  task automatic to_frame_start();
    while ((t % FRAME) != 0) step(1'b0, 16'h0);
  endtask

  initial begin
    int          acks_before;
    logic [15:0] rv;

    // Reset state
    #12;
    check4("rst_en", digit_en, 4'hF);
    check4("rst_bcd", bcd, 4'h0);
    check1("rst_ack", load_ack, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    t = 0;

    // First load at release; ack lands after the first frame wrap.
    step(1'b1, 16'h1234);
    idle(2 * FRAME);
    check4("ack_count_1234", 4'(ack_cnt), 4'd1);

    // Leading-zero blanking on and off.
    blz = 1'b1;
    step(1'b1, 16'h0005);
    idle(2 * FRAME);
    blz = 1'b0;
    idle(FRAME);

    // All zero value: digit 0 still lit.
    blz = 1'b1;
    step(1'b1, 16'h0000);
    idle(2 * FRAME);
    blz = 1'b0;

    // Two loads in one frame: one ack, last value wins.
    to_frame_start();
    idle(1);
    acks_before = ack_cnt;
    step(1'b1, 16'hAAAA);
    idle(5);
    step(1'b1, 16'hBBBB);
    idle(FRAME + 4);
    check4("ack_count_aabb", 4'(ack_cnt - acks_before), 4'd1);

    // Load exactly on the wrap cycle goes straight to the display.
    to_wrap();
    acks_before = ack_cnt;
    step(1'b1, 16'hC0DE);
    check4("ack_count_c0de", 4'(ack_cnt - acks_before), 4'd1);
    idle(FRAME);

    // Random loads and blank toggles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      rv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rv = rv & 16'h00FF;
      step($urandom_range(0, 19) == 0, rv);
    end

    // Reset mid-slot with a pending load: async clear, no ack afterwards.
    to_frame_start();
    idle(3);
    step(1'b1, 16'h9876);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check4("arst_en", digit_en, 4'hF);
    check4("arst_bcd", bcd, 4'h0);
    check1("arst_ack", load_ack, 1'b0);
    @(posedge clk); #1;
    check4("arst_hold_en", digit_en, 4'hF);
    @(posedge clk); #1;
    check4("arst_hold_bcd", bcd, 4'h0);
    rst_n  = 1'b1;
    t      = 0;
    m_disp = '0;
    m_pend = '0;
    m_pv   = 1'b0;
    acks_before = ack_cnt;
    idle(2 * FRAME);
    check4("ack_after_rst", 4'(ack_cnt - acks_before), 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
